// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer: FSM state encoding and run modes.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_UPDN     = 2'b10;
    localparam logic [1:0] MODE_PINGPONG = 2'b11;

    // True in either counting state; busy and the prescaler run both key off this.
    function automatic logic is_run(input state_t s);
        return (s == RUN_UP) || (s == RUN_DOWN);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler: counts run cycles modulo DIV and strobes tick on the last phase.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] phase;

    // Phase advances only while running, so a freeze keeps the position within the step.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
        end else if (run) begin
            phase <= (phase == LAST) ? '0 : phase + 1'b1;
        end
    end

    assign tick = run && (phase == LAST);

endmodule

// File: rtl/counter_sequencer.sv
// Up/down/ping-pong count sequencer stepping once every DIV clocks via tick_divider.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             halt,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             sel,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    state_t           state, next_state;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [WIDTH-1:0] count_d;
    logic             div_clr;
    logic             div_run;
    logic             div_tick;

    assign div_run = is_run(state) && !halt;

    tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .run  (div_run),
        .tick (div_tick)
    );

    // An abort on the same cycle as the last prescale phase must not produce a step.
    assign tick = div_tick && !stop;
    assign sel  = (state == RUN_DOWN);
    assign busy = is_run(state);
    assign done = (state == DONE);

    // State, count and the latched run parameters all update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            mode_q  <= MODE_UP;
            limit_q <= '0;
        end else begin
            state   <= next_state;
            count   <= count_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
        end
    end

    // Next-state and count datapath; stop wins over tick, and the terminal values never wrap.
    always_comb begin
        next_state = state;
        count_d    = count;
        mode_d     = mode_q;
        limit_d    = limit_q;
        div_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    div_clr = 1'b1;
                    mode_d  = mode;
                    limit_d = limit;
                    if (mode == MODE_DOWN) begin
                        count_d    = limit;
                        next_state = RUN_DOWN;
                    end else begin
                        count_d    = '0;
                        next_state = RUN_UP;
                    end
                end
            end
            RUN_UP: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (tick) begin
                    if (count < limit_q) begin
                        count_d = count + 1'b1;
                    end else if (mode_q == MODE_UP) begin
                        next_state = DONE;
                    end else begin
                        next_state = RUN_DOWN;
                    end
                end
            end
            RUN_DOWN: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (tick) begin
                    if (count != '0) begin
                        count_d = count - 1'b1;
                    end else if (mode_q == MODE_PINGPONG) begin
                        next_state = RUN_UP;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer (WIDTH=4, DIV=4) driven by directed runs.
module tb_counter_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       halt;
    logic [1:0] mode;
    logic [3:0] limit;
    logic [3:0] count;
    logic       sel;
    logic       tick;
    logic       busy;
    logic       done;

    typedef struct {
        int         cyc;
        logic [3:0] count;
        logic       sel;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   e0;
    int   checks;
    int   errors;
    logic prev_tick;

    counter_sequencer #(
        .WIDTH (4),
        .DIV   (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .halt  (halt),
        .mode  (mode),
        .limit (limit),
        .count (count),
        .sel   (sel),
        .tick  (tick),
        .busy  (busy),
        .done  (done)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to timestamp every observed step.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case the clock-driven waits ever stall.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Monitor: every cycle following a tick, or any cycle with done high, is one event to match.
    initial prev_tick = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_tick || done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_event at cycle %0d: count=%0d sel=%0b busy=%0b done=%0b",
                         cyc, count, sel, busy, done);
            end else begin
                e = sb.pop_front();
                if (cyc != e.cyc || count != e.count || sel != e.sel ||
                    busy != e.busy || done != e.done) begin
                    errors++;
                    $display("[TB] FAIL step_event got cyc=%0d count=%0d sel=%0b busy=%0b done=%0b, expected cyc=%0d count=%0d sel=%0b busy=%0b done=%0b",
                             cyc, count, sel, busy, done, e.cyc, e.count, e.sel, e.busy, e.done);
                end
            end
        end
        prev_tick = tick && !rst;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Queue an expected event rel edges after the start edge.
    task automatic expectAt(input int rel, input int c, input logic s, input logic b, input logic d);
        exp_t e;
        e.cyc   = e0 + rel;
        e.count = c[3:0];
        e.sel   = s;
        e.busy  = b;
        e.done  = d;
        sb.push_back(e);
    endtask

    // Pulse start for one edge; returns at the negedge just after the start edge (cyc == e0).
    task automatic applyStimulus(input logic [1:0] m, input logic [3:0] l);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        limit = l;
        e0    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        mode  = 2'b00;
        limit = 4'd0;
    endtask

    task automatic waitRel(input int rel);
        while (cyc < e0 + rel) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        halt  = 1'b0;
        mode  = 2'b00;
        limit = 4'd0;
        checks = 0;
        errors = 0;
        e0     = 0;

        // Power-on reset
        repeat (2) @(negedge clk);
        checkOutput("reset_count", int'(count), 0);
        checkOutput("reset_busy",  int'(busy),  0);
        checkOutput("reset_done",  int'(done),  0);
        checkOutput("reset_sel",   int'(sel),   0);
        checkOutput("reset_tick",  int'(tick),  0);
        rst = 1'b0;

        // Reset asserted mid-run wipes everything at the first rst edge
        applyStimulus(2'b00, 4'd5);
        expectAt(4, 1, 1'b0, 1'b1, 1'b0);
        waitRel(5);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_count", int'(count), 0);
        checkOutput("midrst_busy",  int'(busy),  0);
        checkOutput("midrst_done",  int'(done),  0);
        checkOutput("midrst_sel",   int'(sel),   0);
        checkOutput("midrst_tick",  int'(tick),  0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Up-once to 3
        applyStimulus(2'b00, 4'd3);
        checkOutput("up_start_count", int'(count), 0);
        checkOutput("up_start_busy",  int'(busy),  1);
        expectAt(4,  1, 1'b0, 1'b1, 1'b0);
        expectAt(8,  2, 1'b0, 1'b1, 1'b0);
        expectAt(12, 3, 1'b0, 1'b1, 1'b0);
        expectAt(16, 3, 1'b0, 1'b0, 1'b1);
        waitRel(17);
        checkOutput("up_idle_done",  int'(done),  0);
        checkOutput("up_idle_count", int'(count), 3);
        checkOutput("up_idle_busy",  int'(busy),  0);

        // Up-then-down with limit 2
        applyStimulus(2'b10, 4'd2);
        expectAt(4,  1, 1'b0, 1'b1, 1'b0);
        expectAt(8,  2, 1'b0, 1'b1, 1'b0);
        expectAt(12, 2, 1'b1, 1'b1, 1'b0);
        expectAt(16, 1, 1'b1, 1'b1, 1'b0);
        expectAt(20, 0, 1'b1, 1'b1, 1'b0);
        expectAt(24, 0, 1'b0, 1'b0, 1'b1);
        waitRel(25);
        checkOutput("updn_idle_sel",   int'(sel),   0);
        checkOutput("updn_idle_count", int'(count), 0);

        // Ping-pong with limit 1, aborted after the fifth step
        applyStimulus(2'b11, 4'd1);
        expectAt(4,  1, 1'b0, 1'b1, 1'b0);
        expectAt(8,  1, 1'b1, 1'b1, 1'b0);
        expectAt(12, 0, 1'b1, 1'b1, 1'b0);
        expectAt(16, 0, 1'b0, 1'b1, 1'b0);
        expectAt(20, 1, 1'b0, 1'b1, 1'b0);
        waitRel(20);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checkOutput("pp_stop_busy",  int'(busy),  0);
        checkOutput("pp_stop_count", int'(count), 1);
        checkOutput("pp_stop_done",  int'(done),  0);
        repeat (2) @(negedge clk);
        checkOutput("pp_after_done",  int'(done),  0);
        checkOutput("pp_after_count", int'(count), 1);

        // Down-once from 2: count loads with limit immediately
        applyStimulus(2'b01, 4'd2);
        checkOutput("down_start_count", int'(count), 2);
        checkOutput("down_start_sel",   int'(sel),   1);
        expectAt(4,  1, 1'b1, 1'b1, 1'b0);
        expectAt(8,  0, 1'b1, 1'b1, 1'b0);
        expectAt(12, 0, 1'b0, 1'b0, 1'b1);
        waitRel(14);

        // Limit 0 in up-once finishes on the very first step
        applyStimulus(2'b00, 4'd0);
        expectAt(4, 0, 1'b0, 1'b0, 1'b1);
        waitRel(6);
        checkOutput("lim0_count", int'(count), 0);

        // Halt freeze with ignored start pulses, then abort
        applyStimulus(2'b00, 4'd15);
        expectAt(4,  1, 1'b0, 1'b1, 1'b0);
        expectAt(18, 2, 1'b0, 1'b1, 1'b0);
        expectAt(22, 3, 1'b0, 1'b1, 1'b0);
        waitRel(6);
        halt = 1'b1;
        waitRel(10);
        start = 1'b1;
        mode  = 2'b01;
        limit = 4'd7;
        @(negedge clk);
        start = 1'b0;
        mode  = 2'b00;
        limit = 4'd0;
        waitRel(12);
        checkOutput("halt_count", int'(count), 1);
        checkOutput("halt_tick",  int'(tick),  0);
        checkOutput("halt_busy",  int'(busy),  1);
        waitRel(16);
        halt = 1'b0;
        waitRel(19);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_start_sel", int'(sel), 0);
        waitRel(22);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checkOutput("halt_stop_count", int'(count), 3);
        checkOutput("halt_stop_busy",  int'(busy),  0);
        repeat (3) @(negedge clk);

        // Anything still queued was never observed
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL missing_event: expected cyc=%0d count=%0d not observed", e.cyc, e.count);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
